xadc_scheduler: RTL and testbench



---
 rtl/xadc_scheduler_pkg.sv | 18 +
 rtl/xadc_scheduler_rr_arbiter2.sv | 18 +
 rtl/xadc_scheduler.sv | 138 +++++++++++++
 tb/tb_xadc_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_scheduler_pkg.sv
// Shared definitions for the XADC DRP read scheduler and its users:
// FSM encoding, DRP channel addresses, sample and timeout widths.
package xadc_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DRDY = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  localparam int SAMPLE_W = 12;
  localparam int TMO_W    = 8;

  localparam logic [6:0] DRP_ADDR_TEMP = 7'h13;  // VAUX3, material-system temperature
  localparam logic [6:0] DRP_ADDR_AUX  = 7'h1B;  // VAUX11, auxiliary sensor

endpackage

// File: rtl/xadc_scheduler_rr_arbiter2.sv
// Two-way round-robin grant, purely combinational.
// On a tie the requester not served last wins; otherwise the lone requester wins.
module rr_arbiter2 (
  input  logic [1:0] pending,
  input  logic       lastServed,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    if (&pending) begin
      grant = ~lastServed;
    end else begin
      grant = pending[1];
    end
  end

endmodule

// File: rtl/xadc_scheduler.sv
// Arbitrates two single-deep read requesters onto one XADC DRP port.
// readyN/errN pulse drdy-delay+2 cycles after den; a repeated request while pending is merged.
module xadc_scheduler
  import xadc_scheduler_pkg::*;
#(
  parameter logic [6:0]  ADDR0   = DRP_ADDR_TEMP,
  parameter logic [6:0]  ADDR1   = DRP_ADDR_AUX,
  parameter int unsigned TIMEOUT = 255  // legal range 1..255
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req0,
  input  logic                req1,
  output logic                den,
  output logic [6:0]          daddr,
  input  logic                drdy,
  input  logic [15:0]         doIn,
  output logic [SAMPLE_W-1:0] data0,
  output logic [SAMPLE_W-1:0] data1,
  output logic                ready0,
  output logic                ready1,
  output logic                err0,
  output logic                err1,
  output logic                busy
);

  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT);

  state_t              state_q, state_d;
  logic [1:0]          pend_q, pend_d;
  logic [1:0]          rdy_q, rdy_d;
  logic [1:0]          err_q, err_d;
  logic [1:0]          done_clr;
  logic                last_q;
  logic                grant_q;
  logic                arb_grant;
  logic                tmo_q;
  logic [TMO_W-1:0]    cnt_q;
  logic [SAMPLE_W-1:0] data0_q, data1_q;
  logic                unused_lsbs;

  assign unused_lsbs = ^doIn[3:0];

  rr_arbiter2 u_arb (
    .pending    (pend_q),
    .lastServed (last_q),
    .grant      (arb_grant)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The counter reaching 1 in WAIT_DRDY means TIMEOUT wait cycles have elapsed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (|pend_q) state_d = ST_ISSUE;
      ST_ISSUE:     state_d = ST_WAIT_DRDY;
      ST_WAIT_DRDY: if (drdy || (cnt_q == TMO_W'(1))) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    den   = 1'b0;
    daddr = 7'h00;
    busy  = (state_q != ST_IDLE);
    if (state_q == ST_ISSUE) begin
      den   = 1'b1;
      daddr = grant_q ? ADDR1 : ADDR0;
    end
  end

  // A request landing in the DONE cycle re-arms pending after the clear.
  always_comb begin
    done_clr = 2'b00;
    if (state_q == ST_DONE) begin
      done_clr = grant_q ? 2'b10 : 2'b01;
    end
    pend_d = (pend_q & ~done_clr) | {req1, req0};
    rdy_d  = tmo_q ? 2'b00 : done_clr;
    err_d  = tmo_q ? done_clr : 2'b00;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_q  <= 2'b00;
      rdy_q   <= 2'b00;
      err_q   <= 2'b00;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      pend_q <= pend_d;
      rdy_q  <= rdy_d;
      err_q  <= err_d;
      if (state_q == ST_IDLE && |pend_q) begin
        grant_q <= arb_grant;
      end
      if (state_q == ST_ISSUE) begin
        cnt_q <= TMO_LOAD;
        tmo_q <= 1'b0;
      end
      if (state_q == ST_WAIT_DRDY) begin
        cnt_q <= cnt_q - TMO_W'(1);
        if (drdy) begin
          if (grant_q) begin
            data1_q <= doIn[15:4];
          end else begin
            data0_q <= doIn[15:4];
          end
        end else if (cnt_q == TMO_W'(1)) begin
          tmo_q <= 1'b1;
        end
      end
      if (state_q == ST_DONE) begin
        last_q <= grant_q;
      end
    end
  end

  assign data0  = data0_q;
  assign data1  = data1_q;
  assign ready0 = rdy_q[0];
  assign ready1 = rdy_q[1];
  assign err0   = err_q[0];
  assign err1   = err_q[1];

endmodule

// File: tb/tb_xadc_scheduler.sv
// Bench for xadc_scheduler: transaction-timeline reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with sporadic resets.
module tb_xadc_scheduler;

  localparam int TMO = 255;

  logic        CLK   = 1'b0;
  logic        RST   = 1'b1;
  logic        req0  = 1'b0;
  logic        req1  = 1'b0;
  logic        drdy  = 1'b0;
  logic [15:0] doIn  = 16'h0000;
  logic        den;
  logic [6:0]  daddr;
  logic [11:0] data0, data1;
  logic        ready0, ready1, err0, err1, busy;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  xadc_scheduler #(.ADDR0(7'h13), .ADDR1(7'h1B), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .req0(req0), .req1(req1), .den(den), .daddr(daddr),
    .drdy(drdy), .doIn(doIn), .data0(data0), .data1(data1), .ready0(ready0),
    .ready1(ready1), .err0(err0), .err1(err1), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one transaction record (who, den cycle, pulse cycle) on a cycle timeline.
  int          n      = 0;
  logic [1:0]  m_pend = 2'b00;
  logic        m_last = 1'b1;
  bit          m_act  = 1'b0;
  logic        m_who  = 1'b0;
  int          m_D    = 0;
  int          m_fin  = 0;
  bit          m_err  = 1'b0;
  logic [11:0] m_data0 = 12'h000;
  logic [11:0] m_data1 = 12'h000;

  always @(posedge CLK or posedge RST) begin
    logic [1:0] p_prev;
    bit         idle_prev;
    if (RST) begin
      n = 0; m_pend = 2'b00; m_last = 1'b1; m_act = 1'b0; m_who = 1'b0;
      m_D = 0; m_fin = 0; m_err = 1'b0; m_data0 = 12'h000; m_data1 = 12'h000;
    end else begin
      n = n + 1;
      p_prev    = m_pend;
      idle_prev = !m_act || (m_fin != 0 && n - 1 >= m_fin);
      if (m_act && m_fin == 0) begin
        if (drdy && n - 1 >= m_D + 1) begin
          if (m_who) m_data1 = doIn[15:4];
          else       m_data0 = doIn[15:4];
          m_fin = n + 1;
          m_err = 1'b0;
        end else if (n - 1 == m_D + TMO) begin
          m_fin = n + 1;
          m_err = 1'b1;
        end
      end
      if (m_act && m_fin == n) begin
        m_pend[m_who] = 1'b0;
        m_last = m_who;
      end
      m_pend = m_pend | {req1, req0};
      if (idle_prev && p_prev != 2'b00) begin
        m_act = 1'b1;
        m_D   = n;
        m_fin = 0;
        m_err = 1'b0;
        m_who = (p_prev == 2'b11) ? !m_last : p_prev[1];
      end
    end
  end

  always @(negedge CLK) begin
    logic e_den, e_pulse;
    if (cmp_en) begin
      e_den   = m_act && (n == m_D);
      e_pulse = m_act && (m_fin == n);
      chk("den",    32'(den),    32'(e_den));
      chk("daddr",  32'(daddr),  e_den ? (m_who ? 32'h1B : 32'h13) : 32'h0);
      chk("busy",   32'(busy),   32'(m_act && (m_fin == 0 || n < m_fin)));
      chk("ready0", 32'(ready0), 32'(e_pulse && !m_err && !m_who));
      chk("ready1", 32'(ready1), 32'(e_pulse && !m_err && m_who));
      chk("err0",   32'(err0),   32'(e_pulse && m_err && !m_who));
      chk("err1",   32'(err1),   32'(e_pulse && m_err && m_who));
      chk("data0",  32'(data0),  32'(m_data0));
      chk("data1",  32'(data1),  32'(m_data1));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; req0 = 1'b0; req1 = 1'b0; drdy = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic wait_den(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (den) found = 1'b1;
    end
    chk(name, 32'(found), 32'd1);
  endtask

  logic [6:0] addrs[$];

  initial begin
    int r0at, r1cnt, eat, rc, cnt, rat, den2;
    bit rearmed;
    #1;
    cmp_en = 1'b1;

    // Single read on requester 0, drdy three cycles after den.
    do_reset();
    chk("a_rst_busy",  32'(busy),  32'd0);
    chk("a_rst_data0", 32'(data0), 32'd0);
    chk("a_rst_daddr", 32'(daddr), 32'd0);
    req0 = 1'b1; tick(); req0 = 1'b0;
    wait_den("a_den_seen");
    chk("a_daddr", 32'(daddr), 32'h13);
    r0at = -1; r1cnt = 0;
    for (int off = 1; off <= 8; off++) begin
      tick();
      if (off == 3) begin drdy = 1'b1; doIn = 16'h4B00; end
      else drdy = 1'b0;
      if (ready0 && r0at < 0) r0at = off;
      if (ready1) r1cnt++;
    end
    chk("a_ready0_latency", 32'(r0at), 32'd5);
    chk("a_ready1_none",    32'(r1cnt), 32'd0);
    chk("a_data0",          32'(data0), 32'h4B0);

    // Simultaneous requests: 0, then 1, then the next tie goes to 0.
    do_reset();
    addrs.delete();
    drdy = 1'b1; doIn = 16'h1230; req0 = 1'b1; req1 = 1'b1; rearmed = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      req0 = 1'b0; req1 = 1'b0;
      if (den) addrs.push_back(daddr);
      if (ready1 && !rearmed) begin req0 = 1'b1; req1 = 1'b1; rearmed = 1'b1; end
    end
    drdy = 1'b0;
    chk("b_den_count", 32'(addrs.size() >= 3), 32'd1);
    if (addrs.size() >= 3) begin
      chk("b_first",  32'(addrs[0]), 32'h13);
      chk("b_second", 32'(addrs[1]), 32'h1B);
      chk("b_third",  32'(addrs[2]), 32'h13);
    end

    // Timeout on requester 1 keeps the previous sample.
    do_reset();
    doIn = 16'hABC0; drdy = 1'b1; req1 = 1'b1; tick(); req1 = 1'b0;
    repeat (8) tick();
    drdy = 1'b0; doIn = 16'h5550;
    chk("c_pre_data1", 32'(data1), 32'hABC);
    req1 = 1'b1; tick(); req1 = 1'b0;
    wait_den("c_den_seen");
    eat = -1; rc = 0;
    for (int off = 1; off <= 300 && eat < 0; off++) begin
      tick();
      if (err1) eat = off;
      if (ready1) rc++;
    end
    chk("c_err1_latency", 32'(eat),  32'(TMO + 2));
    chk("c_data1_kept",   32'(data1), 32'hABC);
    chk("c_busy_low",     32'(busy),  32'd0);
    chk("c_no_ready1",    32'(rc),    32'd0);

    // Repeated req0 while pending merges into one transaction.
    do_reset();
    req0 = 1'b1; tick(); req0 = 1'b0; tick(); req0 = 1'b1; tick(); req0 = 1'b0;
    tick(); req0 = 1'b1; tick(); req0 = 1'b0; drdy = 1'b1; doIn = 16'h7770;
    tick(); drdy = 1'b0;
    cnt = 32'(ready0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ready0) cnt++;
    end
    chk("d_one_ready0", 32'(cnt), 32'd1);

    // Reset during WAIT_DRDY abandons the read; late drdy is ignored.
    do_reset();
    req1 = 1'b1; tick(); req1 = 1'b0;
    wait_den("e_den_seen");
    tick(); tick();
    RST = 1'b1;
    #1;
    chk("e_busy_in_reset", 32'(busy), 32'd0);
    tick();
    RST = 1'b0; drdy = 1'b1; doIn = 16'hFFF0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) drdy = 1'b0;
      if (ready0 || ready1 || err0 || err1 || den) cnt++;
    end
    chk("e_no_pulses", 32'(cnt),   32'd0);
    chk("e_busy",      32'(busy),  32'd0);
    chk("e_data1",     32'(data1), 32'd0);

    // req0 during its own ready0 starts the next read straight away.
    do_reset();
    drdy = 1'b1; doIn = 16'h0010; req0 = 1'b1; tick(); req0 = 1'b0;
    rat = -1; den2 = -1;
    for (int off = 1; off <= 20; off++) begin
      tick();
      req0 = 1'b0;
      if (ready0 && rat < 0) begin rat = off; req0 = 1'b1; end
      else if (den && rat >= 0 && den2 < 0) den2 = off;
    end
    drdy = 1'b0;
    chk("f_ready_seen", 32'(rat >= 0), 32'd1);
    chk("f_second_gap", 32'(den2 - rat), 32'd2);

    // Randomized traffic, including sporadic resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      tick();
      req0 = ($urandom_range(0, 99) < 12);
      req1 = ($urandom_range(0, 99) < 12);
      drdy = ($urandom_range(0, 99) < 30);
      doIn = 16'($urandom);
      RST  = ($urandom_range(0, 999) < 3);
    end
    RST = 1'b0; req0 = 1'b0; req1 = 1'b0; drdy = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
